qpacket_tx: RTL

Transmit-side counterpart to the per-node learning pipeline. After the decision chain finishes (`done_selectMyAction`), this block fetches the Q-value for the chosen next hop from node memory. It then emits a six-word feedback packet over a valid/ready word stream. The fields are destination, source, cluster, battery, value and checksum: exactly the fields a neighbour's `learnCosts` consumes. The block sits beside the action-selection stage and takes one memory-mux slot (read-only).

---
 rtl/qpacket_tx_if.sv | 11 +
 rtl/qpacket_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/qpacket_tx_if.sv
// Word-stream link carrying feedback packets from qpacket_tx to the network sink.
// The master drives data/valid/last and the slave drives ready.
interface qpacket_tx_if;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, input  tx_last, output tx_ready);
endinterface

// File: rtl/qpacket_tx.sv
// Feedback packet transmitter: fetches the chosen next hop's Q-value and emits
// dest/src/cluster/battery/value/checksum as six words on a valid/ready stream.
module qpacket_tx #(
    parameter logic [15:0] QVALUE_BASE   = 16'h01C8,
    parameter int unsigned MAX_NEIGHBORS = 64
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic [15:0]         MY_NODE_ID,
    input  logic [15:0]         MY_CLUSTER_ID,
    input  logic [15:0]         MY_BATTERY_STAT,
    input  logic [15:0]         nexthop,
    input  logic [15:0]         nexthop_idx,
    output logic [15:0]         address,
    input  logic [15:0]         mem_data_out,
    qpacket_tx_if.master        tx,
    output logic                done,
    output logic                err
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(5);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, FIN} state_t;

    state_t             state, state_n;
    logic               start_d, start_d_n;
    logic [WORD_W-1:0]  dest_q, dest_n;
    logic [WORD_W-1:0]  src_q, src_n;
    logic [WORD_W-1:0]  cluster_q, cluster_n;
    logic [WORD_W-1:0]  batt_q, batt_n;
    logic [WORD_W-1:0]  qval_q, qval_n;
    logic [WORD_W-1:0]  csum_q, csum_n;
    logic [CNT_W-1:0]   wcnt_q, wcnt_n;
    logic [WORD_W-1:0]  address_q, address_n;
    logic [WORD_W-1:0]  tx_data_q, tx_data_n;
    logic               tx_valid_q, tx_valid_n;
    logic               tx_last_q, tx_last_n;
    logic               done_q, done_n;
    logic               err_q, err_n;

    logic               launch_c;
    logic               idx_bad_c;
    logic               handshake_c;
    logic [CNT_W-1:0]   wcnt_inc_c;
    logic [WORD_W-1:0]  next_word_c;
    logic [WORD_W-1:0]  sum_c;

    assign launch_c    = start && !start_d && en && (state == IDLE);
    assign idx_bad_c   = 32'(nexthop_idx) >= MAX_NEIGHBORS;
    assign handshake_c = tx_valid_q && tx.tx_ready;
    assign wcnt_inc_c  = CNT_W'(wcnt_q + CNT_W'(1));
    // Qval comes straight from memory here because it is captured on the same edge.
    assign sum_c       = dest_q + src_q + cluster_q + batt_q + mem_data_out;

    // Word that follows the one currently on the bus.
    always_comb begin
        next_word_c = csum_q;
        case (wcnt_inc_c)
            CNT_W'(0): next_word_c = dest_q;
            CNT_W'(1): next_word_c = src_q;
            CNT_W'(2): next_word_c = cluster_q;
            CNT_W'(3): next_word_c = batt_q;
            CNT_W'(4): next_word_c = qval_q;
            default:   next_word_c = csum_q;
        endcase
    end

    // State register and all registered outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            start_d    <= 1'b0;
            dest_q     <= '0;
            src_q      <= '0;
            cluster_q  <= '0;
            batt_q     <= '0;
            qval_q     <= '0;
            csum_q     <= '0;
            wcnt_q     <= '0;
            address_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            start_d    <= start_d_n;
            dest_q     <= dest_n;
            src_q      <= src_n;
            cluster_q  <= cluster_n;
            batt_q     <= batt_n;
            qval_q     <= qval_n;
            csum_q     <= csum_n;
            wcnt_q     <= wcnt_n;
            address_q  <= address_n;
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
            tx_last_q  <= tx_last_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        start_d_n  = start;
        dest_n     = dest_q;
        src_n      = src_q;
        cluster_n  = cluster_q;
        batt_n     = batt_q;
        qval_n     = qval_q;
        csum_n     = csum_q;
        wcnt_n     = wcnt_q;
        address_n  = address_q;
        tx_data_n  = tx_data_q;
        tx_valid_n = tx_valid_q;
        tx_last_n  = tx_last_q;
        done_n     = done_q;
        err_n      = err_q;

        case (state)
            IDLE: begin
                if (launch_c) begin
                    dest_n    = nexthop;
                    src_n     = MY_NODE_ID;
                    cluster_n = MY_CLUSTER_ID;
                    batt_n    = MY_BATTERY_STAT;
                    done_n    = 1'b0;
                    err_n     = 1'b0;
                    if (idx_bad_c) begin
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        state_n = FIN;
                    end else begin
                        address_n = QVALUE_BASE + WORD_W'(nexthop_idx << 1);
                        state_n   = FETCH;
                    end
                end
            end
            FETCH: begin
                state_n = LATCH;
            end
            LATCH: begin
                qval_n     = mem_data_out;
                csum_n     = ~sum_c;
                wcnt_n     = '0;
                address_n  = '0;
                tx_data_n  = dest_q;
                tx_valid_n = 1'b1;
                tx_last_n  = 1'b0;
                state_n    = SEND;
            end
            SEND: begin
                if (handshake_c) begin
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_n     = '0;
                        tx_data_n  = '0;
                        tx_valid_n = 1'b0;
                        tx_last_n  = 1'b0;
                        done_n     = 1'b1;
                        state_n    = FIN;
                    end else begin
                        wcnt_n    = wcnt_inc_c;
                        tx_data_n = next_word_c;
                        tx_last_n = (wcnt_inc_c == LAST_WORD);
                    end
                end
            end
            FIN: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign address     = address_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_last  = tx_last_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
